uart_rx_fsm: RTL
================

// Module: uart_rx_fsm
// PURPOSE
// Receive-side counterpart of the UART transmitter FSM: recovers frames from the serial line.
// Frame format: start(0), DATA_WIDTH data bits LSB-first, one parity bit, one stop bit(1); line idles high.
// tx_clk runs at OVERSAMPLE x baud. Each bit is sampled once, at its centre.
// The block presents each completed byte with a one-cycle valid strobe and per-frame error flags.
// PARAMETERS
// DATA_WIDTH  8   data bits per frame (must match the transmitter's `DATA_WIDTH)
// OVERSAMPLE  16  tx_clk cycles per bit period; even, >= 4
// PARITY_ODD  0   0 = even parity expected, 1 = odd parity expected
// PORTS
// tx_clk      in   1           clock, OVERSAMPLE x baud
// resetn      in   1           reset, synchronous, active-low
// rx          in   1           asynchronous serial input
// rx_data     out  DATA_WIDTH  last received data word; held until the next frame completes
// rx_valid    out  1           one-cycle pulse when rx_data/flags update
// parity_err  out  1           parity mismatch on the last frame; qualified by rx_valid, held
// frame_err   out  1           stop bit sampled 0 on the last frame; qualified by rx_valid, held
// busy        out  1           high in every state except IDLE
// BEHAVIOUR
// - Reset (resetn=0 at a tx_clk edge): state=IDLE, sync flops=1, rx_prev=1, tick/bit counters=0.
//   Outputs on reset: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0.
//   Reset mid-frame aborts the frame silently: no rx_valid, flags cleared.
// - rx passes through a 2-flop synchronizer (rx_s); rx_prev = rx_s delayed by 1 cycle.
// - Tick counter width is $clog2(OVERSAMPLE). It is cleared on every state entry.
// - States:
//   IDLE: go to START on a falling edge, i.e. rx_prev=1 && rx_s=0.
//         A line held low (break) never starts a frame.
//   START: at tick OVERSAMPLE/2-1, sample rx_s.
//          0 -> DATA (tick=0, bit=0). 1 -> false start, IDLE with no output.
//   DATA: at tick OVERSAMPLE-1, sample into a shift register (shift right, new bit into MSB).
//         After sampling bit DATA_WIDTH-1, go to PARITY.
//   PARITY: at tick OVERSAMPLE-1, capture p.
//           perr = (^shift ^ p) != PARITY_ODD.
//   STOP: at tick OVERSAMPLE-1, sample the stop bit, then on the same edge:
//         - rx_data <= shift
//         - parity_err <= perr
//         - frame_err <= ~rx_s
//         - rx_valid <= 1
//         - state <= IDLE
// - All sample points are bit centres, offset by the fixed 2-cycle synchronizer delay.
// - rx_valid is high for exactly one tx_clk cycle, starting the cycle after the stop-bit centre sample.
// - rx_valid is asserted even when an error flag is set; the consumer qualifies on the flags.
// - The FSM is back in IDLE at mid-stop-bit, so a start bit immediately after the stop bit is caught.
// - busy = (state != IDLE); it drops in the same cycle rx_valid rises.
// - Unused state encodings go to IDLE.
// TESTING
// 1. Send 0xA5 with even parity (p=0) and stop=1 -> rx_data=0xA5, rx_valid is a single pulse, both errs=0.
// 2. Drive rx low for 4 ticks, then high -> START rejects at the mid-point, returns to IDLE, no rx_valid, busy pulses only.
// 3. Send 0x01 with p=0 (even expected, 1 required) -> rx_valid=1, parity_err=1, rx_data=0x01.
// 4. Send 0x3C with stop=0, then hold rx low for 3 frames -> one rx_valid with frame_err=1, then no further frames until rx returns high and falls again.
// 5. Send 0x00 then 0xFF back-to-back, with no idle time between frames -> two rx_valid pulses with the correct data; PARITY_ODD=1 variant also checked.
// 6. Assert resetn=0 during DATA bit 3 -> all outputs return to their reset values; the next 0x5A frame is received correctly.

Source files
------------

// File: rtl/uart_rx_fsm.sv
// UART receiver: 2-flop synchronized line, centre-sampled start/data/parity/stop bits,
// one-cycle valid strobe with held data and per-frame parity/framing flags.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                  tx_clk,
    input  logic                  resetn,
    input  logic                  rx,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic          ODD_PAR   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state_reg, state_next;
    logic [TW-1:0]           tick_reg, tick_next;
    logic [BW-1:0]           bit_reg, bit_next;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic                    perr_reg, perr_next;
    logic [DATA_WIDTH-1:0]   data_reg, data_next;
    logic                    valid_reg, valid_next;
    logic                    pe_reg, pe_next;
    logic                    fe_reg, fe_next;
    logic                    rx_meta, rx_s, rx_prev;

    // Synchronizer flops reset high so an idle line never looks like a falling edge.
    always_ff @(posedge tx_clk) begin
        if (!resetn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
            tick_reg  <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            perr_reg  <= 1'b0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            pe_reg    <= 1'b0;
            fe_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            tick_reg  <= tick_next;
            bit_reg   <= bit_next;
            shift_reg <= shift_next;
            perr_reg  <= perr_next;
            data_reg  <= data_next;
            valid_reg <= valid_next;
            pe_reg    <= pe_next;
            fe_reg    <= fe_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tick_next  = tick_reg + 1'b1;
        bit_next   = bit_reg;
        shift_next = shift_reg;
        perr_next  = perr_reg;
        data_next  = data_reg;
        valid_next = 1'b0;
        pe_next    = pe_reg;
        fe_next    = fe_reg;

        unique case (state_reg)
            IDLE: begin
                tick_next = '0;
                if (rx_prev && !rx_s) state_next = START;
            end
            START: begin
                if (tick_reg == TICK_MID) begin
                    tick_next  = '0;
                    bit_next   = '0;
                    state_next = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (tick_reg == TICK_END) begin
                    tick_next  = '0;
                    shift_next = {rx_s, shift_reg[DATA_WIDTH-1:1]};
                    bit_next   = bit_reg + 1'b1;
                    if (bit_reg == BIT_LAST) state_next = PARITY;
                end
            end
            PARITY: begin
                if (tick_reg == TICK_END) begin
                    tick_next  = '0;
                    perr_next  = ((^shift_reg) ^ rx_s) != ODD_PAR;
                    state_next = STOP;
                end
            end
            STOP: begin
                // Leaving at mid-stop-bit lets an immediately following start edge be seen.
                if (tick_reg == TICK_END) begin
                    tick_next  = '0;
                    data_next  = shift_reg;
                    pe_next    = perr_reg;
                    fe_next    = ~rx_s;
                    valid_next = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                tick_next  = '0;
                state_next = IDLE;
            end
        endcase
    end

    assign rx_data    = data_reg;
    assign rx_valid   = valid_reg;
    assign parity_err = pe_reg;
    assign frame_err  = fe_reg;
    assign busy       = (state_reg != IDLE);

endmodule
